// File: rtl/dm_pkg.sv
// dm_pkg: shared types, sizes and address-legality helper for data-memory access
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned DM_BYTES_DEF = 256;
  localparam int unsigned WORD_BYTES   = 4;

  // A word access is legal when aligned and the whole word fits inside the memory
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned dm_bytes);
    return (addr[1:0] == 2'b00) && (addr <= 32'(dm_bytes - WORD_BYTES));
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; pointer names the requester favoured on a tie
module rr_arb2 #(
  parameter bit RST_PRIO = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // Grant the favoured requester on a tie; after any win favour the loser side
  always_comb begin
    gnt_o = (req_i == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req_i;
    ptr_d = (adv_i && gnt_o != 2'b00) ? ~gnt_o[1] : ptr_q;
  end

  // Pointer register, returns to the reset favourite
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= RST_PRIO;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sequencer sharing one data-memory port between two requesters
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned DM_BYTES = DM_BYTES_DEF,
  parameter bit          RST_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_done0,
  output logic        o_done1,
  output logic        o_err0,
  output logic        o_err1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  input  logic [31:0] i_dm_rdata
);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [1:0]  gnt;
  logic        adv, win, win_we, win_ok;
  logic [31:0] win_addr, win_wdata;

  assign adv       = (state_q == IDLE) && (i_req0 || i_req1);
  assign win       = gnt[1];
  assign win_we    = win ? i_we1 : i_we0;
  assign win_addr  = win ? i_addr1 : i_addr0;
  assign win_wdata = win ? i_wdata1 : i_wdata0;
  assign win_ok    = addr_legal(win_addr, DM_BYTES);

  rr_arb2 #(.RST_PRIO(RST_PRIO)) u_rr (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .req_i ({i_req1, i_req0}),
    .adv_i (adv),
    .gnt_o (gnt)
  );

  // Next state: latch the winner in IDLE, drive memory in ACCESS, answer in RESP
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    err_d      = err_q;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      IDLE: if (adv) begin
        owner_d = win;
        we_d    = win_we;
        err_d   = !win_ok;
        state_d = win_ok ? ACCESS : RESP;
        if (win_ok) begin
          dm_we_d    = win_we;
          dm_addr_d  = win_addr;
          dm_wdata_d = win_wdata;
        end else if (win) rdata1_d = '0;
        else rdata0_d = '0;
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q) rdata1_d = we_q ? '0 : i_dm_rdata;
        else rdata0_d = we_q ? '0 : i_dm_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight access
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      err_q      <= err_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign o_done0    = (state_q == RESP) && !owner_q;
  assign o_done1    = (state_q == RESP) && owner_q;
  assign o_err0     = o_done0 && err_q;
  assign o_err1     = o_done1 && err_q;
  assign o_rdata0   = rdata0_q;
  assign o_rdata1   = rdata1_q;
  assign o_dm_we    = dm_we_q;
  assign o_dm_addr  = dm_addr_q;
  assign o_dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural big-endian memory
module tb_dm_arbiter;

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        done0, done1, err0, err1, dm_we;
  logic [31:0] rdata0, rdata1, dm_addr, dm_wdata, dm_rdata;
  logic [7:0]  mem [256];
  wire  [7:0]  ma = dm_addr[7:0];
  int          cyc = 0;
  int          we_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  dm_arbiter #(.DM_BYTES(256), .RST_PRIO(1'b0)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req0    (req0),
    .i_req1    (req1),
    .i_we0     (we0),
    .i_we1     (we1),
    .i_addr0   (addr0),
    .i_addr1   (addr1),
    .i_wdata0  (wdata0),
    .i_wdata1  (wdata1),
    .o_done0   (done0),
    .o_done1   (done1),
    .o_err0    (err0),
    .o_err1    (err1),
    .o_rdata0  (rdata0),
    .o_rdata1  (rdata1),
    .o_dm_we   (dm_we),
    .o_dm_addr (dm_addr),
    .o_dm_wdata(dm_wdata),
    .i_dm_rdata(dm_rdata)
  );

  assign dm_rdata = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_we) begin
      mem[ma]         <= dm_wdata[31:24];
      mem[ma + 8'd1]  <= dm_wdata[23:16];
      mem[ma + 8'd2]  <= dm_wdata[15:8];
      mem[ma + 8'd3]  <= dm_wdata[7:0];
    end
  end

  always @(negedge clk) if (dm_we) we_cnt <= we_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_tx(input bit p, input bit err, input bit chk_rd, input logic [31:0] rd, input int dc);
    sbq.push_back('{port: p, err: err, chk_rd: chk_rd, rd: rd, cyc: cyc + dc});
  endtask

  task automatic drive(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    int n;
    if (p) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? done1 : done0) && n < 20);
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL done_timeout: port %0d got no done expected done within 20 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  // Monitor: every completion pulse is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (done0 || done1)) begin
      if (done0 && done1) chk("both_done", {done1, done0}, 32'd1);
      else if (sbq.size() == 0) chk("unexpected_done", {done1, done0}, 32'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("done_port", 32'(done1), 32'(mon_e.port));
        chk("done_cycle", mon_e.port ? 32'(cyc) : 32'(cyc), 32'(mon_e.cyc));
        chk("err", 32'(done1 ? err1 : err0), 32'(mon_e.err));
        chk("other_err", 32'(done1 ? err0 : err1), 32'd0);
        if (mon_e.chk_rd) chk("rdata", done1 ? rdata1 : rdata0, mon_e.rd);
      end
    end
  end

  initial begin
    int c;
    int w0;
    logic [31:0] bad [3];
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i ^ 8'h5A);
    mem[8'h10] <= 8'hDE;
    mem[8'h11] <= 8'hAD;
    mem[8'h12] <= 8'hBE;
    mem[8'h13] <= 8'hEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", {done1, done0, err1, err0, dm_we}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_rdata", rdata0 | rdata1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // contention from reset: 0,1,0,1 one done every 3 cycles; first is the single read of 0x10
    expect_tx(0, 0, 1, 32'hDEADBEEF, 2);
    expect_tx(1, 0, 1, 32'h4E4F4C4D, 5);
    expect_tx(0, 0, 1, 32'h42434041, 8);
    expect_tx(1, 0, 1, 32'h46474445, 11);
    fork
      begin drive(0, 0, 32'h10, 0); drive(0, 0, 32'h18, 0); end
      begin drive(1, 0, 32'h14, 0); drive(1, 0, 32'h1C, 0); end
    join
    chk("reads_no_we", 32'(we_cnt), 32'd0);
    // write then readback on requester 1
    w0 = we_cnt;
    expect_tx(1, 0, 0, 0, 2);
    drive(1, 1, 32'h20, 32'h12345678);
    chk("write_we_once", 32'(we_cnt), 32'(w0 + 1));
    chk("mem20", 32'(mem[8'h20]), 32'h12);
    chk("mem23", 32'(mem[8'h23]), 32'h78);
    expect_tx(1, 0, 1, 32'h12345678, 2);
    drive(1, 0, 32'h20, 0);
    // rejected addresses on requester 0, which currently holds 0x42434041
    w0 = we_cnt;
    bad[0] = 32'h21;
    bad[1] = 32'hFD;
    bad[2] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      expect_tx(0, 1, 1, 32'd0, 1);
      drive(0, 1'(i != 2), bad[i], 32'hAAAAAAAA);
    end
    chk("err_no_we", 32'(we_cnt), 32'(w0));
    chk("err_mem21", 32'(mem[8'h21]), 32'h34);
    chk("err_memFD", 32'(mem[8'hFD]), 32'(8'hFD ^ 8'h5A));
    // last legal word
    expect_tx(0, 0, 0, 0, 2);
    drive(0, 1, 32'hFC, 32'hCAFEF00D);
    chk("memFC", {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]}, 32'hCAFEF00D);
    expect_tx(1, 0, 1, 32'hCAFEF00D, 2);
    drive(1, 0, 32'hFC, 0);
    chk("rdata0_hold", rdata0, 32'd0);
    // reset while a write by requester 0 sits in ACCESS
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    chk("access_we", 32'(dm_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_drop", 32'(dm_we), 32'd0);
    req0 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mem40_kept", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h1A1B1819);
    expect_tx(0, 0, 1, 32'h1A1B1819, 2);
    expect_tx(1, 0, 1, 32'hDEADBEEF, 5);
    fork
      drive(0, 0, 32'h40, 0);
      drive(1, 0, 32'h10, 0);
    join
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got no finish expected finish before 20000");
    $fatal(1);
  end

endmodule
